div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle 32-bit radix-2 restoring divider for DIV/DIVU in the E stage.
- Produces the stall_div request that the hazard unit turns into stallE/stallM, and the {hi, lo} result written to HI/LO.
- The E stage holds div_start high while the divide instruction sits in E; the unit holds stall_div until the result is ready.
- An exception flush annuls an in-flight divide.

Parameters:
- WIDTH, 32, operand and quotient/remainder width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- div_start  input  1  divide instruction present in E; held high while stalled.
- div_signed  input  1  1 = DIV (signed), 0 = DIVU; sampled at accept.
- annul  input  1  exception flush (flush_except); aborts any operation.
- opa  input  WIDTH  dividend (rs); sampled at accept only.
- opb  input  WIDTH  divisor (rt); sampled at accept only.
- stall_div  output  1  stall request to hazard unit.
- result_valid  output  1  one-cycle pulse; hi/lo are valid this cycle.
- hi  output  WIDTH  remainder.
- lo  output  WIDTH  quotient.

Behaviour:
- Reset: state IDLE, counter 0, and all internal registers 0. Outputs: stall_div 0, result_valid 0, hi 0, lo 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Accept when div_start=1 and annul=0. On accept, capture |opa| and |opb| (absolute values only if div_signed=1), the sign of the quotient (opa[31]^opb[31]) and the sign of the remainder (opa[31]), both gated by div_signed.
  - If opb==0: next state DONE with quotient=all ones and remainder=opa (raw value).
  - Otherwise: next state BUSY, counter=0, partial remainder=0.
- BUSY:
  - Each cycle, shift {rem, quo} left by 1, then trial-subtract the divisor from rem. If no borrow, keep the difference and set quo[0]=1.
  - Counter increments. After iteration WIDTH (counter reaches WIDTH-1 and is processed), next state DONE.
- DONE:
  - result_valid=1 for exactly this cycle.
  - lo = quotient, negated if the quotient sign is set. hi = remainder, negated if the remainder sign is set.
  - hi/lo are registered and hold their value until the next DONE.
  - Next state IDLE unconditionally.
- stall_div = div_start & ~annul & (state != DONE). It is combinational and lets E advance in the DONE cycle.
- Latency, nonzero divisor:
  - Accept in cycle 0, BUSY in cycles 1..32, DONE in cycle 33.
  - stall_div is high in cycles 0..32 (33 cycles) and low in cycle 33.
- Latency, divisor zero: accept in cycle 0, DONE in cycle 1. stall_div is high for 1 cycle.
- Back-to-back divides: a new div_start in the cycle after DONE is accepted from IDLE normally. div_start high during DONE is never re-accepted.
- annul (highest priority):
  - In any state, next state is IDLE. No result_valid is produced and hi/lo are unchanged.
  - Annul in the same cycle as div_start in IDLE means no accept.
  - Annul in DONE suppresses result_valid and leaves hi/lo unchanged.
- div_start dropping low while BUSY (should not happen) does not abort. The operation completes and result_valid still pulses.
- Operand changes after accept are ignored.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraparound, no trap).
- Asynchronous rst mid-operation: immediate return to reset values with no result.

Test Plan:
- DIVU 100/7: start held, div_signed=0 -> stall_div high 33 cycles; cycle 33 result_valid=1, lo=14, hi=2.
- DIV -7/2 (0xFFFFFFF9/2), signed -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also 7/-2 -> lo=-3, hi=1.
- Divide by zero, opa=0x1234 -> DONE after 1 stall cycle; lo=0xFFFFFFFF, hi=0x1234.
- annul pulsed in BUSY cycle 10 -> stall_div drops that cycle, no result_valid, hi/lo retain previous result; next start is accepted normally from IDLE.
- Back-to-back: 100/7 then 0x80000000/0xFFFFFFFF signed, with start held across -> two result_valid pulses 34 cycles apart; second gives lo=0x80000000, hi=0.
- rst asserted asynchronously mid-BUSY -> all outputs 0 immediately; operation after reset release returns the correct result.

Source files
------------

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the E stage.
// Produces the E/M stall request and the {hi, lo} result for HI/LO.
module div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic             annul,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             stall_div,
  output logic             result_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             qneg_q;
  logic             rneg_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             a_neg_d;
  logic             b_neg_d;
  logic [WIDTH-1:0] abs_a_d;
  logic [WIDTH-1:0] abs_b_d;
  logic [WIDTH:0]   shift_d;
  logic             fits_d;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic             last_d;

  // Operand magnitudes at accept and one shift/trial-subtract step.
  // The shifted remainder needs WIDTH+1 bits when the divisor has its MSB set.
  always_comb begin
    a_neg_d = div_signed & opa[WIDTH-1];
    b_neg_d = div_signed & opb[WIDTH-1];
    abs_a_d = a_neg_d ? (~opa + WIDTH'(1)) : opa;
    abs_b_d = b_neg_d ? (~opb + WIDTH'(1)) : opb;
    shift_d = {rem_q, quo_q[WIDTH-1]};
    fits_d  = shift_d >= {1'b0, dvs_q};
    rem_d   = fits_d ? (shift_d[WIDTH-1:0] - dvs_q) : shift_d[WIDTH-1:0];
    quo_d   = {quo_q[WIDTH-2:0], fits_d};
    last_d  = cnt_q == CNT_W'(WIDTH - 1);
  end

  // Sign correction is folded into the final iteration so DONE only presents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (annul) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (div_start) begin
            if (opb == '0) begin
              quo_q   <= '1;
              rem_q   <= opa;
              state_q <= DONE;
            end else begin
              quo_q   <= abs_a_d;
              rem_q   <= '0;
              dvs_q   <= abs_b_d;
              cnt_q   <= '0;
              qneg_q  <= a_neg_d ^ b_neg_d;
              rneg_q  <= a_neg_d;
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_d) begin
            quo_q   <= qneg_q ? (~quo_d + WIDTH'(1)) : quo_d;
            rem_q   <= rneg_q ? (~rem_d + WIDTH'(1)) : rem_d;
            state_q <= DONE;
          end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
          end
        end
        DONE: begin
          hi_q    <= rem_q;
          lo_q    <= quo_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Result is visible in the DONE cycle itself; an annul there keeps the old HI/LO.
  always_comb begin
    stall_div    = div_start & ~annul & (state_q != DONE);
    result_valid = (state_q == DONE) & ~annul;
    hi           = result_valid ? rem_q : hi_q;
    lo           = result_valid ? quo_q : lo_q;
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: arithmetic reference model checked every cycle,
// plus literal expectations for the headline divide cases.
module tb_div_unit;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             div_start = 1'b0;
  logic             div_signed = 1'b0;
  logic             annul = 1'b0;
  logic [WIDTH-1:0] opa = '0;
  logic [WIDTH-1:0] opb = '0;
  logic             stall_div;
  logic             result_valid;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  div_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .div_start(div_start), .div_signed(div_signed),
    .annul(annul), .opa(opa), .opb(opb), .stall_div(stall_div),
    .result_valid(result_valid), .hi(hi), .lo(lo)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // {hi, lo} from plain arithmetic; 64-bit signed math avoids the MIN/-1 overflow.
  function automatic logic [63:0] calc(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {32'(r), 32'(q)};
    end
    return {a % b, a / b};
  endfunction

  // Protocol model: phase 0 idle, 1 dividing, 2 result cycle.
  int          ph = 0;
  int          left = 0;
  logic [63:0] pend = '0;
  logic [63:0] held = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph   <= 0;
      left <= 0;
      pend <= '0;
      held <= '0;
    end else if (annul) begin
      ph <= 0;
    end else begin
      case (ph)
        0: if (div_start) begin
          pend <= calc(opa, opb, div_signed);
          if (opb == 32'd0) ph <= 2;
          else begin
            ph   <= 1;
            left <= WIDTH;
          end
        end
        1: begin
          left <= left - 1;
          if (left == 1) ph <= 2;
        end
        default: begin
          held <= pend;
          ph   <= 0;
        end
      endcase
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic        e_rv;
    logic        e_stall;
    logic [63:0] e_res;
    e_rv    = (ph == 2) && !annul;
    e_stall = div_start && !annul && (ph != 2);
    e_res   = e_rv ? pend : held;
    chk("model_stall", 32'(stall_div), 32'(e_stall));
    chk("model_rv", 32'(result_valid), 32'(e_rv));
    chk("model_hi", hi, e_res[63:32]);
    chk("model_lo", lo, e_res[31:0]);
  end

  // Issue one divide; counts stall cycles, garbles operands after accept,
  // optionally drops div_start mid-divide or keeps it high for back-to-back.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic [31:0] elo, input logic [31:0] ehi, input int estall,
                         input bit hold, input bit drop, output int rv_cyc);
    int  n = 0;
    bit  got = 0;
    @(posedge clk); #1;
    opa = a; opb = b; div_signed = sgn; div_start = 1'b1;
    rv_cyc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (result_valid) begin
        got = 1;
        rv_cyc = cyc;
        break;
      end
      if (stall_div) n++;
      if (i == 0) begin
        @(posedge clk); #1;
        opa = ~a; opb = b + 32'd7;
      end
      if (drop && i == 3) begin
        @(posedge clk); #1;
        div_start = 1'b0;
      end
    end
    chk("rv_seen", 32'(got), 32'd1);
    chk("lit_lo", lo, elo);
    chk("lit_hi", hi, ehi);
    chk("stall_cycles", 32'(n), 32'(estall));
    if (!hold) begin
      @(posedge clk); #1;
      div_start = 1'b0;
    end
  endtask

  // Annul k cycles after start; result must never appear and HI/LO stay put.
  task automatic annul_at(input int k, input logic [31:0] olo, input logic [31:0] ohi);
    bit seen = 0;
    @(posedge clk); #1;
    opa = 32'd100; opb = 32'd7; div_signed = 1'b0; div_start = 1'b1;
    repeat (k) @(posedge clk);
    #1 annul = 1'b1;
    @(negedge clk);
    chk("annul_stall", 32'(stall_div), 32'd0);
    chk("annul_rv", 32'(result_valid), 32'd0);
    chk("annul_lo", lo, olo);
    chk("annul_hi", hi, ohi);
    @(posedge clk); #1;
    annul = 1'b0; div_start = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (result_valid) seen = 1;
    end
    chk("annul_no_rv", 32'(seen), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1);
  end

  initial begin
    int t1, t2;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_stall", 32'(stall_div), 32'd0);
    chk("reset_rv", 32'(result_valid), 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);

    run_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33, 0, 0, t1);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 0, 0, t1);
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 33, 0, 0, t1);
    run_div(32'h1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234, 1, 0, 0, t1);
    run_div(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 32'd1, 32'd1, 33, 0, 0, t1);
    run_div(32'hFFFF_FFFF, 32'd3, 1'b0, 32'h5555_5555, 32'd0, 33, 0, 0, t1);

    annul_at(0, 32'h5555_5555, 32'd0);
    annul_at(10, 32'h5555_5555, 32'd0);
    annul_at(33, 32'h5555_5555, 32'd0);

    run_div(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 4, 0, 1, t1);

    run_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33, 1, 0, t1);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 33, 0, 0, t2);
    chk("b2b_gap", 32'(t2 - t1), 32'd34);

    // Asynchronous reset in the middle of a divide.
    @(posedge clk); #1;
    opa = 32'd100; opb = 32'd7; div_signed = 1'b0; div_start = 1'b1;
    repeat (5) @(posedge clk);
    #3 div_start = 1'b0; rst = 1'b1;
    #1;
    chk("arst_stall", 32'(stall_div), 32'd0);
    chk("arst_rv", 32'(result_valid), 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    @(negedge clk); #2 rst = 1'b0;
    run_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33, 0, 0, t1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
